// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-setting front end: FSM states,
// BCD time layout, field/button indices and the power-on default time.
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_SEC  = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] shi;
        logic [3:0] ge;
    } bcd2_t;

    typedef struct packed {
        bcd2_t hour;
        bcd2_t min;
        bcd2_t sec;
    } hms_t;

    // Field index doubles as the pair position inside blink_mask.
    localparam int FIELD_SEC  = 0;
    localparam int FIELD_MIN  = 1;
    localparam int FIELD_HOUR = 2;

    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;

    localparam hms_t  DEFAULT_TIME = 24'h12_00_00;
    localparam bcd2_t HOUR_MAX     = 8'h23;
    localparam bcd2_t MINSEC_MAX   = 8'h59;

endpackage

// File: rtl/time_set_ctrl_if.sv
// Time bus between time_set_ctrl and the running clock / display logic:
// current time in, committed set time, commit strobe and edit status out.
interface time_set_ctrl_if;
    logic [3:0] cur_sec_ge;
    logic [3:0] cur_sec_shi;
    logic [3:0] cur_min_ge;
    logic [3:0] cur_min_shi;
    logic [3:0] cur_hour_ge;
    logic [3:0] cur_hour_shi;
    logic [3:0] set_sec_ge;
    logic [3:0] set_sec_shi;
    logic [3:0] set_min_ge;
    logic [3:0] set_min_shi;
    logic [3:0] set_hour_ge;
    logic [3:0] set_hour_shi;
    logic       set_time_finish;
    logic       edit_active;
    logic [5:0] blink_mask;

    modport slave (
        input  cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
        output set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
        output set_time_finish, edit_active, blink_mask
    );

    modport master (
        output cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
        input  set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
        input  set_time_finish, edit_active, blink_mask
    );
endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle pulse when the accepted level rises.
module time_set_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            press     <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press     <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    press     <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hour/minute/second editor: debounced MODE/INC walk the fields,
// a final MODE commits the edited time with a one-cycle strobe.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 500_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int TIMEOUT      = 500_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn_mode,
    input  logic           btn_inc,
    time_set_ctrl_if.slave tsc
);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    btn_raw;
    logic [1:0]    btn_evt;
    logic          mode_evt;
    logic          inc_evt;
    logic          is_edit;
    logic          timeout_hit;
    hms_t          cur_time;
    hms_t          edit_reg;
    hms_t          set_reg;
    state_t        state_reg;
    logic          finish_reg;
    logic          phase_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic [TW-1:0] to_cnt_reg;
    logic [5:0]    blink_mask_next;

    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t top);
        bcd2_t r;
        if (v == top) begin
            r = '0;
        end else if (v.ge == 4'd9) begin
            r.shi = v.shi + 4'd1;
            r.ge  = 4'd0;
        end else begin
            r.shi = v.shi;
            r.ge  = v.ge + 4'd1;
        end
        return r;
    endfunction

    assign btn_raw[BTN_MODE] = btn_mode;
    assign btn_raw[BTN_INC]  = btn_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            time_set_ctrl_btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (btn_raw[gi]),
                .press(btn_evt[gi])
            );
        end
    endgenerate

    assign mode_evt = btn_evt[BTN_MODE];
    assign inc_evt  = btn_evt[BTN_INC];
    assign cur_time = {tsc.cur_hour_shi, tsc.cur_hour_ge, tsc.cur_min_shi,
                       tsc.cur_min_ge, tsc.cur_sec_shi, tsc.cur_sec_ge};

    assign is_edit = (state_reg == ST_EDIT_HOUR) || (state_reg == ST_EDIT_MIN) ||
                     (state_reg == ST_EDIT_SEC);
    assign timeout_hit = is_edit && !mode_evt && !inc_evt &&
                         (to_cnt_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            edit_reg      <= DEFAULT_TIME;
            set_reg       <= DEFAULT_TIME;
            finish_reg    <= 1'b0;
            phase_reg     <= 1'b0;
            blink_cnt_reg <= '0;
            to_cnt_reg    <= '0;
        end else begin
            finish_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (mode_evt) begin
                        edit_reg  <= cur_time;
                        state_reg <= ST_EDIT_HOUR;
                    end
                end
                ST_EDIT_HOUR: begin
                    if (mode_evt)         state_reg     <= ST_EDIT_MIN;
                    else if (inc_evt)     edit_reg.hour <= bcd_inc(edit_reg.hour, HOUR_MAX);
                    else if (timeout_hit) state_reg     <= ST_IDLE;
                end
                ST_EDIT_MIN: begin
                    if (mode_evt)         state_reg    <= ST_EDIT_SEC;
                    else if (inc_evt)     edit_reg.min <= bcd_inc(edit_reg.min, MINSEC_MAX);
                    else if (timeout_hit) state_reg    <= ST_IDLE;
                end
                ST_EDIT_SEC: begin
                    // Commit is registered here so set_* and the strobe appear together.
                    if (mode_evt) begin
                        state_reg  <= ST_COMMIT;
                        set_reg    <= edit_reg;
                        finish_reg <= 1'b1;
                    end else if (inc_evt) begin
                        edit_reg.sec <= bcd_inc(edit_reg.sec, MINSEC_MAX);
                    end else if (timeout_hit) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_COMMIT: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase

            if (is_edit && !mode_evt && !inc_evt && !timeout_hit) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end else begin
                to_cnt_reg <= '0;
            end

            // A field change (mode) or leaving edit restarts the blink from the lit phase.
            if (is_edit && !mode_evt && !timeout_hit) begin
                if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end else begin
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b0;
            end
        end
    end

    always_comb begin
        blink_mask_next = 6'b000000;
        if (phase_reg) begin
            case (state_reg)
                ST_EDIT_HOUR: blink_mask_next[2*FIELD_HOUR +: 2] = 2'b11;
                ST_EDIT_MIN:  blink_mask_next[2*FIELD_MIN  +: 2] = 2'b11;
                ST_EDIT_SEC:  blink_mask_next[2*FIELD_SEC  +: 2] = 2'b11;
                default:      blink_mask_next = 6'b000000;
            endcase
        end
    end

    assign tsc.set_hour_shi    = set_reg.hour.shi;
    assign tsc.set_hour_ge     = set_reg.hour.ge;
    assign tsc.set_min_shi     = set_reg.min.shi;
    assign tsc.set_min_ge      = set_reg.min.ge;
    assign tsc.set_sec_shi     = set_reg.sec.shi;
    assign tsc.set_sec_ge      = set_reg.sec.ge;
    assign tsc.set_time_finish = finish_reg;
    assign tsc.edit_active     = is_edit;
    assign tsc.blink_mask      = blink_mask_next;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences, commit values checked
// by a scoreboard monitor on set_time_finish.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    int checks = 0;
    int failures = 0;
    int finish_count = 0;
    logic prev_fin = 1'b0;
    logic [23:0] exp_q[$];

    time_set_ctrl_if ifc ();

    time_set_ctrl #(
        .DEB_CYCLES  (4),
        .BLINK_CYCLES(8),
        .TIMEOUT     (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .tsc     (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] get_set();
        return {ifc.set_hour_shi, ifc.set_hour_ge, ifc.set_min_shi,
                ifc.set_min_ge, ifc.set_sec_shi, ifc.set_sec_ge};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic set_cur(input logic [23:0] t);
        {ifc.cur_hour_shi, ifc.cur_hour_ge, ifc.cur_min_shi,
         ifc.cur_min_ge, ifc.cur_sec_shi, ifc.cur_sec_ge} = t;
    endtask

    task automatic press(input logic m, input logic i, input int hold);
        @(posedge clk);
        #1;
        btn_mode = m;
        btn_inc  = i;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic glitch_inc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1 btn_inc = 1'b1;
            repeat (3) @(posedge clk);
            #1 btn_inc = 1'b0;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic wait_blink(output logic [5:0] mask);
        mask = 6'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifc.blink_mask != 6'b0) begin
                mask = ifc.blink_mask;
                break;
            end
        end
    endtask

    // Scoreboard monitor: every strobe must match the next queued commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin <= 1'b0;
        end else begin
            if (ifc.set_time_finish) begin
                finish_count++;
                if (prev_fin) check("finish_width", 24'd2, 24'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_finish", get_set(), 24'hFFFFFF);
                end else begin
                    check("commit_time", get_set(), exp_q.pop_front());
                end
            end
            prev_fin <= ifc.set_time_finish;
        end
    end

    initial begin
        logic [5:0] mask;
        set_cur(24'h00_00_00);

        // 1: reset then idle
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("rst_set", get_set(), 24'h12_00_00);
        check("rst_finish", 24'(ifc.set_time_finish), 24'd0);
        check("rst_edit", 24'(ifc.edit_active), 24'd0);
        check("rst_mask", 24'(ifc.blink_mask), 24'd0);

        // 2: glitches ignored, long hold gives one increment (09 -> 10)
        set_cur(24'h09_30_15);
        press(1'b1, 1'b0, 8);
        check("edit_entered", 24'(ifc.edit_active), 24'd1);
        glitch_inc(4);
        press(1'b0, 1'b1, 20);
        wait_blink(mask);
        check("blink_hour", 24'(mask), 24'(6'b110000));
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        exp_q.push_back(24'h10_30_15);
        press(1'b1, 1'b0, 8);

        // 3: wrap every field without cross-field carry
        set_cur(24'h23_59_58);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        exp_q.push_back(24'h00_00_00);
        press(1'b1, 1'b0, 8);

        // 4: timeout discards edits
        set_cur(24'h05_06_07);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("timeout_edit", 24'(ifc.edit_active), 24'd0);
        check("timeout_mask", 24'(ifc.blink_mask), 24'd0);
        check("timeout_set", get_set(), 24'h00_00_00);

        // 5: simultaneous mode+inc in EDIT_MIN -> mode wins
        set_cur(24'h14_25_37);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b1, 8);
        wait_blink(mask);
        check("blink_sec", 24'(mask), 24'(6'b000011));
        exp_q.push_back(24'h14_25_37);
        press(1'b1, 1'b0, 8);

        // 6: asynchronous reset in EDIT_SEC
        set_cur(24'h01_02_03);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_set", get_set(), 24'h12_00_00);
        check("arst_finish", 24'(ifc.set_time_finish), 24'd0);
        check("arst_edit", 24'(ifc.edit_active), 24'd0);
        check("arst_mask", 24'(ifc.blink_mask), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check("pending_commits", 24'(exp_q.size()), 24'd0);
        check("finish_count", 24'(finish_count), 24'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
